// File: rtl/dffram_arbiter.sv
// Round-robin arbiter sharing one single-port DFFRAM between a CPU port (p0) and a DMA port (p1).
// All RAM controls are registered; ack/rdata are decoded from state, last grant and ram_do.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no access in flight; grant any requester
// S_ACCESS | RAM controls valid, RAM samples at the end of this cycle
// S_ACK    | ack the active port; may grant the other port directly

module dffram_arbiter #(
    parameter int COLS = 1,
    localparam int A_WIDTH = 8 + $clog2(COLS)
) (
    input  logic               CLK,
    input  logic               resetn,
    input  logic               p0_req,
    input  logic [3:0]         p0_we,
    input  logic [A_WIDTH-1:0] p0_addr,
    input  logic [31:0]        p0_wdata,
    output logic               p0_ack,
    output logic [31:0]        p0_rdata,
    input  logic               p1_req,
    input  logic [3:0]         p1_we,
    input  logic [A_WIDTH-1:0] p1_addr,
    input  logic [31:0]        p1_wdata,
    output logic               p1_ack,
    output logic [31:0]        p1_rdata,
    output logic               ram_en,
    output logic [3:0]         ram_we,
    output logic [A_WIDTH-1:0] ram_a,
    output logic [31:0]        ram_di,
    input  logic [31:0]        ram_do
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               ram_en_q, ram_en_d;
    logic [3:0]         ram_we_q, ram_we_d;
    logic [A_WIDTH-1:0] ram_a_q, ram_a_d;
    logic [31:0]        ram_di_q, ram_di_d;
    logic               grant;
    logic               win;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        ram_en_d = ram_en_q;
        ram_we_d = ram_we_q;
        ram_a_d  = ram_a_q;
        ram_di_d = ram_di_q;
        grant    = 1'b0;
        win      = 1'b0;

        case (state_q)
            S_IDLE: begin
                ram_en_d = 1'b0;
                ram_we_d = 4'h0;
                if (p0_req || p1_req) begin
                    grant = 1'b1;
                    win   = (p0_req && p1_req) ? ~last_q : p1_req;
                end
            end
            S_ACCESS: begin
                ram_en_d = 1'b0;
                ram_we_d = 4'h0;
                state_d  = S_ACK;
            end
            S_ACK: begin
                ram_en_d = 1'b0;
                ram_we_d = 4'h0;
                state_d  = S_IDLE;
                // The acked port still holds req this cycle, so only the other port counts.
                if (last_q ? p0_req : p1_req) begin
                    grant = 1'b1;
                    win   = ~last_q;
                end
            end
            default: begin
                ram_en_d = 1'b0;
                ram_we_d = 4'h0;
                state_d  = S_IDLE;
            end
        endcase

        if (grant) begin
            state_d  = S_ACCESS;
            last_d   = win;
            ram_en_d = 1'b1;
            ram_we_d = win ? p1_we    : p0_we;
            ram_a_d  = win ? p1_addr  : p0_addr;
            ram_di_d = win ? p1_wdata : p0_wdata;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            ram_en_q <= 1'b0;
            ram_we_q <= 4'h0;
            ram_a_q  <= '0;
            ram_di_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            ram_en_q <= ram_en_d;
            ram_we_q <= ram_we_d;
            ram_a_q  <= ram_a_d;
            ram_di_q <= ram_di_d;
        end
    end

    assign ram_en   = ram_en_q;
    assign ram_we   = ram_we_q;
    assign ram_a    = ram_a_q;
    assign ram_di   = ram_di_q;

    assign p0_ack   = (state_q == S_ACK) && !last_q;
    assign p1_ack   = (state_q == S_ACK) &&  last_q;
    assign p0_rdata = p0_ack ? ram_do : 32'h0;
    assign p1_rdata = p1_ack ? ram_do : 32'h0;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Bench for dffram_arbiter: behavioural RAM, grant-spacing reference model, directed and random traffic.
module tb_dffram_arbiter;
    localparam int AW = 10;

    logic          CLK = 1'b0;
    logic          resetn = 1'b1;
    logic          p0_req = 1'b0, p1_req = 1'b0;
    logic [3:0]    p0_we = 4'h0, p1_we = 4'h0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [31:0]   p0_wdata = 32'h0, p1_wdata = 32'h0;
    logic          p0_ack, p1_ack;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_a;
    logic [31:0]   ram_di;
    logic [31:0]   ram_do = 32'h0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit armed = 1'b0;

    dffram_arbiter #(.COLS(4)) dut (
        .CLK(CLK), .resetn(resetn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pre(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Stand-in for the DFFRAM macro: registered read, byte writes, Do = 0 when disabled.
    logic [31:0] ram_mem [1024];
    always @(posedge CLK) begin
        if (ram_en) begin
            ram_do <= ram_mem[ram_a];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
        end else begin
            ram_do <= 32'h0;
        end
    end

    // Reference model: tracks edges since the last grant. A grant makes the RAM
    // busy for one edge, the ack follows, and at the ack edge only the other port
    // may be served; from then on any requester, ties going to the port not last served.
    logic [31:0]   gmem [1024];
    int            since = 3;
    logic          m_last = 1'b1;
    logic [3:0]    act_we = 4'h0;
    logic [AW-1:0] act_a = '0;
    logic [31:0]   act_di = 32'h0;
    logic          e_en = 1'b0, e_ack0 = 1'b0, e_ack1 = 1'b0;
    logic [31:0]   e_rd0 = 32'h0, e_rd1 = 32'h0;

    always @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            since = 3; m_last = 1'b1; act_we = 4'h0; act_a = '0; act_di = 32'h0;
            e_en = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0; e_rd0 = 32'h0; e_rd1 = 32'h0;
        end else begin
            logic win;
            logic do_grant;
            if (since < 3) since++;
            e_en = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0; e_rd0 = 32'h0; e_rd1 = 32'h0;
            do_grant = 1'b0; win = 1'b0;
            if (since == 1) begin
                if (m_last) begin e_ack1 = 1'b1; e_rd1 = gmem[act_a]; end
                else        begin e_ack0 = 1'b1; e_rd0 = gmem[act_a]; end
                for (int b = 0; b < 4; b++)
                    if (act_we[b]) gmem[act_a][8*b +: 8] = act_di[8*b +: 8];
            end
            if (since == 2) begin
                if (m_last ? p0_req : p1_req) begin do_grant = 1'b1; win = ~m_last; end
            end else if (since >= 3 && (p0_req || p1_req)) begin
                do_grant = 1'b1;
                win = (p0_req && p1_req) ? ~m_last : p1_req;
            end
            if (do_grant) begin
                m_last = win; since = 0; e_en = 1'b1;
                act_we = win ? p1_we : p0_we;
                act_a  = win ? p1_addr : p0_addr;
                act_di = win ? p1_wdata : p0_wdata;
            end
        end
    end

    always @(negedge CLK) begin
        if (armed) begin
            check("ram_en", 32'(ram_en), 32'(e_en));
            check("ram_we", 32'(ram_we), e_en ? 32'(act_we) : 32'h0);
            check("ram_a", 32'(ram_a), 32'(act_a));
            check("ram_di", ram_di, act_di);
            check("p0_ack", 32'(p0_ack), 32'(e_ack0));
            check("p1_ack", 32'(p1_ack), 32'(e_ack1));
            check("p0_rdata", p0_rdata, e_rd0);
            check("p1_rdata", p1_rdata, e_rd1);
        end
    end

    // Starts right away (caller is just past a rising edge), holds req until ack, then drops it.
    task automatic access(input int port, input logic [3:0] we, input logic [AW-1:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output int ack_cyc,
                          output int lat);
        int k = 0;
        bit got = 1'b0;
        rd = 32'h0; ack_cyc = -1;
        if (port == 0) begin p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1; end
        else           begin p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1; end
        while (!got && k < 24) begin
            @(negedge CLK);
            k++;
            if (port == 0 ? p0_ack : p1_ack) begin
                got = 1'b1;
                rd = (port == 0) ? p0_rdata : p1_rdata;
                ack_cyc = cyc;
            end
        end
        lat = k - 1;
        if (!got) begin
            checks++; failures++;
            $display("FAIL ack_timeout port=%0d actual=no_ack required=ack", port);
        end
        @(posedge CLK);
        #1;
        if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
    endtask

    task automatic rand_port(input int port, input int n);
        logic [31:0] rd;
        int ac, lat;
        for (int i = 0; i < n; i++) begin
            logic [3:0] we;
            logic [AW-1:0] a;
            repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
            we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            a  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'(10'h3F8 + $urandom_range(0, 7));
            access(port, we, a, $urandom, rd, ac, lat);
            check("wait_bound", 32'(lat <= 4), 32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int ac, lat, nack;
        int acs [4];
        int ac0 [3], ac1 [3];
        logic [31:0] rd0 [3], rd1 [3];

        for (int i = 0; i < 1024; i++) begin ram_mem[i] = pre(i); gmem[i] = pre(i); end

        #2 resetn = 1'b0;
        armed = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_en", 32'(ram_en), 32'h0);
        check("rst_we", 32'(ram_we), 32'h0);
        check("rst_a", 32'(ram_a), 32'h0);
        check("rst_di", ram_di, 32'h0);
        check("rst_acks", 32'({p0_ack, p1_ack}), 32'h0);
        check("rst_rdata", p0_rdata | p1_rdata, 32'h0);
        resetn = 1'b1;
        @(posedge CLK); #1;

        access(0, 4'hF, 10'h005, 32'hDEADBEEF, rd, ac, lat);
        check("wr_latency", 32'(lat), 32'd2);
        access(0, 4'h0, 10'h005, 32'h0, rd, ac, lat);
        check("rd_latency", 32'(lat), 32'd2);
        check("rd_deadbeef", rd, 32'hDEADBEEF);

        access(1, 4'hF, 10'h010, 32'h11223344, rd, ac, lat);
        access(1, 4'b0101, 10'h010, 32'hAABBCCDD, rd, ac, lat);
        access(1, 4'h0, 10'h010, 32'h0, rd, ac, lat);
        check("byte_mask", rd, 32'h11BB33DD);

        access(1, 4'hF, 10'h3FF, 32'h0000CAFE, rd, ac, lat);
        access(0, 4'h0, 10'h3FF, 32'h0, rd, ac, lat);
        check("col_3ff", rd, 32'h0000CAFE);
        access(0, 4'h0, 10'h0FF, 32'h0, rd, ac, lat);
        check("col_0ff", rd, 32'hA50000FF);

        for (int i = 0; i < 4; i++) access(0, 4'h0, AW'(i + 2), 32'h0, rd, acs[i], lat);
        for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(acs[i] - acs[i-1]), 32'd3);

        // Reset while a write sits in ACCESS: the write must never land.
        p0_we = 4'hF; p0_addr = 10'h020; p0_wdata = 32'h12345678; p0_req = 1'b1;
        @(posedge CLK); #2;
        check("en_in_access", 32'(ram_en), 32'h1);
        resetn = 1'b0;
        #1;
        check("en_async_drop", 32'(ram_en), 32'h0);
        p0_req = 1'b0;
        repeat (2) @(negedge CLK);
        resetn = 1'b1;
        nack = 0;
        repeat (5) begin @(negedge CLK); if (p0_ack || p1_ack) nack++; end
        check("no_ack_after_rst", 32'(nack), 32'h0);
        @(posedge CLK); #1;
        access(0, 4'h0, 10'h020, 32'h0, rd, ac, lat);
        check("lost_write", rd, 32'hA5000020);

        // Both ports requesting across reset release: p0 first, then strict alternation.
        @(posedge CLK); #1;
        resetn = 1'b0;
        fork
            for (int i = 0; i < 3; i++) access(0, 4'h0, 10'h000, 32'h0, rd0[i], ac0[i], lat);
            for (int i = 0; i < 3; i++) access(1, 4'h0, 10'h001, 32'h0, rd1[i], ac1[i], lat);
            begin repeat (2) @(negedge CLK); resetn = 1'b1; end
        join
        for (int i = 0; i < 3; i++) begin
            check("cont_rd0", rd0[i], 32'hA5000000);
            check("cont_rd1", rd1[i], 32'hA5000001);
            check("cont_p1_after_p0", 32'(ac1[i] - ac0[i]), 32'd2);
            if (i < 2) check("cont_p0_after_p1", 32'(ac0[i+1] - ac1[i]), 32'd2);
        end

        @(posedge CLK); #1;
        fork
            rand_port(0, 150);
            rand_port(1, 150);
        join
        repeat (4) @(posedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dffram_arbiter.md
# dffram_arbiter

Two-port arbiter and access sequencer for a single-port `DFFRAM` macro (32-bit words, 4 byte-write enables, 1-cycle registered read). It lets two requesters share one RAM instance: port 0 is the CPU/Wishbone side and port 1 is the DMA/housekeeping side. It registers every RAM control signal, grants access round-robin, and returns read data with a single-cycle acknowledge.

## Interface

**Parameters**
- `COLS`, default 1: number of 256-word columns in the attached RAM.
- `A_WIDTH`, derived local = 8 + $clog2(COLS): word-address width.

**Ports** (clock and reset first)
- `CLK` input 1: single clock; the arbiter and the RAM share it.
- `resetn` input 1: asynchronous, active-low reset. Asserts immediately; release is synchronous to `CLK`.
- `p0_req` / `p1_req` input 1: access request. Must be held, with all request fields stable, until the matching `ack`.
- `p0_we` / `p1_we` input 4: byte write enables. 4'b0000 means read.
- `p0_addr` / `p1_addr` input A_WIDTH: word address.
- `p0_wdata` / `p1_wdata` input 32: write data.
- `p0_ack` / `p1_ack` output 1: one-cycle completion pulse.
- `p0_rdata` / `p1_rdata` output 32: read data. Valid only while the matching `ack` = 1, and 0 otherwise.
- `ram_en` output 1: to RAM `EN`. Registered.
- `ram_we` output 4: to RAM `WE`. Registered.
- `ram_a` output A_WIDTH: to RAM `A`. Registered.
- `ram_di` output 32: to RAM `Di`. Registered.
- `ram_do` input 32: from RAM `Do`. The RAM drives 0 when it is not enabled.

## Operation

**FSM states:** IDLE, ACCESS, ACK.

**State register `last`:** 1 bit, the port most recently granted. Reset value is 1, so port 0 wins the first tie.

**Arbitration:**
- When only one port requests, that port wins.
- When both request, the port ≠ `last` wins.

**IDLE**
- If any request is pending, select a winner, load `ram_en` = 1 and the winner's we/addr/wdata into the RAM registers, set `last` = winner, and go to ACCESS.
- Otherwise stay in IDLE with `ram_en` = 0.

**ACCESS**
- The RAM samples its inputs at the end of this cycle.
- Next state is ACK.
- `ram_en` and `ram_we` are loaded to 0.
- `ram_a` and `ram_di` hold their values.

**ACK**
- `pN_ack` = 1 for the active port, and `pN_rdata` = `ram_do`.
- For writes, rdata carries the pre-write word. This is harmless, and requesters ignore it.
- Next-state choice:
  - If the other port (≠ `last`) is requesting, issue its access directly: load the RAM registers, set `last`, go to ACCESS.
  - Otherwise go to IDLE.
- The just-acknowledged port's `req` is ignored during ACK, because it is still high that cycle.

**Write masking:** any `we` pattern is passed through unchanged. Partial-byte writes are the RAM's concern.

**Outputs:** `ack` and `rdata` are decoded combinationally from the state, the active port and `ram_do`. No other output path is combinational.

## Timing

- **Reset values:** state = IDLE, `last` = 1, `ram_en` = 0, `ram_we` = 0, `ram_a` = 0, `ram_di` = 0, both `ack` = 0, both `rdata` = 0.
- **Latency:** `req` is sampled high at edge n. `ram_en` is high during cycle n..n+1 and the RAM captures at edge n+1. `ack` is high in the cycle after edge n+1. The requester samples `ack`/`rdata` at edge n+2. Request-to-ack is 2 cycles.
- **Throughput:**
  - Alternating ports give one access per 2 cycles.
  - One port alone gives one access per 3 cycles (ACK → IDLE → ACCESS).
- **Fairness:** under continuous contention the ports strictly alternate. The worst-case wait is one foreign access, i.e. an ack at most 4 cycles after request.
- **`ram_en` discipline:**
  - `ram_en` is never high for two consecutive cycles.
  - `ram_en` is never high while the FSM is in ACK.
- **Request dropped early** (protocol violation): the access already issued completes and `ack` still pulses, with no side effects beyond that.
- **Reset mid-operation:** `ram_en` drops asynchronously and no `ack` is issued. An in-flight write that has not yet reached the RAM's sampling edge is lost. The requester must re-issue after reset.
- **Simultaneous `req` arrival** in IDLE: resolved by `last` as above. The loser's `ack` follows exactly 2 cycles after the winner's `ack`.

## Test plan

1. **Reset state:** assert `resetn` = 0 mid-ACCESS. Required: `ram_en` = 0 immediately, no `ack` after release, all outputs at their reset values.
2. **Single-port write then read:**
   - p0 writes 0xDEADBEEF to address 0x05 with we = 4'hF; `p0_ack` occurs 2 cycles after `req`.
   - p0 then reads 0x05; `p0_rdata` = 0xDEADBEEF in the `ack` cycle.
   - `p1_ack` stays 0 throughout.
3. **Byte masking:**
   - p1 writes 0x11223344 to address 0x10 with we = 4'hF.
   - p1 then writes 0xAABBCCDD with we = 4'b0101.
   - A read of 0x10 returns 0x11BB33DD.
4. **Contention / round-robin:**
   - Both ports hold `req` from reset release: p0 reads 0x00, p1 reads 0x01, with memory preloaded.
   - Grants alternate p0, p1, p0, … with `ack`s spaced exactly 2 cycles apart.
   - Each `rdata` matches its own port's address.
5. **Back-to-back same port:** p0 issues 4 consecutive reads with p1 idle. Acks are spaced 3 cycles apart, and `ram_en` is never high on adjacent cycles.
6. **Column addressing:** with COLS = 4 (A_WIDTH = 10), p1 writes 0x0000CAFE to address 0x3FF and p0 reads 0x3FF. `p0_rdata` = 0x0000CAFE, and address 0x0FF is unchanged.
